// File: rtl/data_mem_pkg.sv
// Shared state encoding, access-field constants and parity helper for the MEM-stage
// burst data memory.
package data_mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t BEAT0 = 2'd1;
  localparam state_t BEAT1 = 2'd2;

  localparam logic SIZE_WORD  = 1'b0;
  localparam logic SIZE_DWORD = 1'b1;
  localparam logic RW_READ    = 1'b1;
  localparam logic RW_WRITE   = 1'b0;

  // Widest word the parity helper covers; narrower words are zero-extended.
  localparam int unsigned PARITY_MAX_W = 64;

  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word storage: synchronous write, asynchronous read, synchronous whole-array
// clear. DATA_W includes the parity bit when the parity build is selected.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ADDRESS_SPACE = 12
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     we,
  input  logic [ADDRESS_SPACE-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_SPACE;

  logic [DATA_W-1:0] store_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        store_q[i] <= '0;
      end
    end else if (we) begin
      store_q[addr] <= wdata;
    end
  end

  assign rdata = store_q[addr];

endmodule

// File: rtl/data_mem_burst.sv
// MEM-stage data memory with single/double-word registered accesses and busy/done handshake.
// Define DATA_MEM_PARITY_EN for per-word even parity, parity_err reporting and inj_par.
module data_mem_burst
  import data_mem_pkg::*;
#(
  parameter int unsigned WORD_LENGTH   = 16,
  parameter int unsigned ADDRESS_SPACE = 12,
  parameter bit          RESET_CLEARS  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem,
  input  logic                     rw,
  input  logic                     size,
  input  logic [ADDRESS_SPACE-1:0] MAR,
  input  logic [2*WORD_LENGTH-1:0] MDR_in,
`ifdef DATA_MEM_PARITY_EN
  input  logic                     inj_par,
`endif
  output logic [2*WORD_LENGTH-1:0] MDR_out,
  output logic                     busy,
  output logic                     done,
  output logic                     addr_err,
  output logic                     parity_err
);

  localparam int unsigned W = WORD_LENGTH;
  localparam int unsigned AW = ADDRESS_SPACE;
`ifdef DATA_MEM_PARITY_EN
  localparam int unsigned CELL_W = W + 1;
`else
  localparam int unsigned CELL_W = W;
`endif
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  state_t          state_q, state_d;
  logic            rw_q, size_q, bad_addr_q;
  logic [AW-1:0]   addr_q;
  logic [2*W-1:0]  wdata_q;
  logic [W-1:0]    upper_q;
  logic            upper_bad_q;

  logic            arr_we;
  logic [AW-1:0]   arr_addr;
  logic [W-1:0]    arr_wword;
  logic [CELL_W-1:0] arr_wdata, arr_rdata;
  logic            rd_bad;

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    arr_we    = 1'b0;
    arr_addr  = addr_q;
    arr_wword = (size_q == SIZE_DWORD) ? wdata_q[2*W-1:W] : wdata_q[W-1:0];
    case (state_q)
      IDLE: begin
        if (mem) state_d = BEAT0;
      end
      BEAT0: begin
        arr_we  = (rw_q == RW_WRITE) && !bad_addr_q;
        state_d = (size_q == SIZE_DWORD && !bad_addr_q) ? BEAT1 : IDLE;
      end
      BEAT1: begin
        arr_addr  = addr_q + AW'(1);
        arr_wword = wdata_q[W-1:0];
        arr_we    = (rw_q == RW_WRITE);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DATA_MEM_PARITY_EN
  logic inj_par_q;
  // Stored bit makes the cell even; inj_par_q deliberately corrupts it.
  assign arr_wdata = {even_parity({{(PARITY_MAX_W-W){1'b0}}, arr_wword}) ^ inj_par_q, arr_wword};
  assign rd_bad = even_parity({{(PARITY_MAX_W-W){1'b0}}, arr_rdata[W-1:0]}) != arr_rdata[W];
`else
  assign arr_wdata = arr_wword;
  assign rd_bad    = 1'b0;
`endif

  data_mem_array #(
    .DATA_W        (CELL_W),
    .ADDRESS_SPACE (AW)
  ) u_array (
    .clk   (clk),
    .clear (!reset && RESET_CLEARS),
    .we    (arr_we && reset),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rw_q        <= RW_READ;
      size_q      <= SIZE_WORD;
      bad_addr_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      upper_q     <= '0;
      upper_bad_q <= 1'b0;
      MDR_out     <= '0;
      done        <= 1'b0;
      addr_err    <= 1'b0;
      parity_err  <= 1'b0;
`ifdef DATA_MEM_PARITY_EN
      inj_par_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      done       <= 1'b0;
      addr_err   <= 1'b0;
      parity_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem) begin
            rw_q       <= rw;
            size_q     <= size;
            addr_q     <= MAR;
            wdata_q    <= MDR_in;
            // No wrap-around: a double access at the top word is refused whole.
            bad_addr_q <= (size == SIZE_DWORD) && (MAR == LAST_ADDR);
`ifdef DATA_MEM_PARITY_EN
            inj_par_q  <= inj_par;
`endif
          end
        end
        BEAT0: begin
          if (bad_addr_q) begin
            done     <= 1'b1;
            addr_err <= 1'b1;
          end else if (size_q == SIZE_WORD) begin
            done <= 1'b1;
            if (rw_q == RW_READ) begin
              MDR_out    <= {{W{1'b0}}, arr_rdata[W-1:0]};
              parity_err <= rd_bad;
            end
          end else begin
            upper_q     <= arr_rdata[W-1:0];
            upper_bad_q <= rd_bad;
          end
        end
        BEAT1: begin
          done <= 1'b1;
          if (rw_q == RW_READ) begin
            MDR_out    <= {upper_q, arr_rdata[W-1:0]};
            parity_err <= upper_bad_q | rd_bad;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_burst.sv
// Directed bench for data_mem_burst: scoreboard of expected completions against a reference
// memory model, checked with immediate assertions.
module tb_data_mem_burst;

  logic        clk, reset, mem, rw, size, inj_par;
  logic [11:0] MAR;
  logic [31:0] MDR_in, MDR_out;
  logic        busy, done, addr_err, parity_err;

`ifdef DATA_MEM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  data_mem_burst #(
    .WORD_LENGTH   (16),
    .ADDRESS_SPACE (12),
    .RESET_CLEARS  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (mem),
    .rw         (rw),
    .size       (size),
    .MAR        (MAR),
    .MDR_in     (MDR_in),
`ifdef DATA_MEM_PARITY_EN
    .inj_par    (inj_par),
`endif
    .MDR_out    (MDR_out),
    .busy       (busy),
    .done       (done),
    .addr_err   (addr_err),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        ae;
    logic        pe;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_mem [4096];
  logic        ref_bad [4096];
  logic [31:0] last_rd;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          ndone;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = '0;
      ref_bad[i] = 1'b0;
    end
    last_rd = '0;
    exp_q.delete();
  endtask

  // Drive a request (mem left high) and push its expected completion.
  task automatic issue(input logic r, input logic s, input logic [11:0] a,
                       input logic [31:0] d, input logic inj);
    exp_t        e;
    logic [11:0] a1;
    logic        badp;
    mem = 1'b1; rw = r; size = s; MAR = a; MDR_in = d; inj_par = inj;
    a1   = a + 12'd1;
    badp = inj_par & PAR_EN;
    e.ae  = s && (a == 12'hFFF);
    e.pe  = 1'b0;
    e.lat = (s && !e.ae) ? 2 : 1;
    if (!e.ae) begin
      if (!r) begin
        if (s) begin
          ref_mem[a]  = d[31:16]; ref_bad[a]  = badp;
          ref_mem[a1] = d[15:0];  ref_bad[a1] = badp;
        end else begin
          ref_mem[a] = d[15:0];   ref_bad[a] = badp;
        end
      end else if (s) begin
        last_rd = {ref_mem[a], ref_mem[a1]};
        e.pe    = ref_bad[a] | ref_bad[a1];
      end else begin
        last_rd = {16'h0000, ref_mem[a]};
        e.pe    = ref_bad[a];
      end
    end
    e.data = last_rd;
    exp_q.push_back(e);
  endtask

  task automatic check_done_now(input string tag);
    exp_t e;
    check({tag, "_sb"}, 32'(exp_q.size()), 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_mdr"}, MDR_out, e.data);
      check({tag, "_aerr"}, {31'd0, addr_err}, {31'd0, e.ae});
      check({tag, "_perr"}, {31'd0, parity_err}, {31'd0, e.pe});
    end
  endtask

  // Called at the first negedge after the accepting edge.
  task automatic wait_done(input string tag);
    int cyc = 0;
    int busy_cnt = 0;
    int lat = (exp_q.size() > 0) ? exp_q[0].lat : 1;
    while (done !== 1'b1 && cyc < 8) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
    check({tag, "_busycyc"}, 32'(busy_cnt), 32'(lat));
    check_done_now(tag);
  endtask

  task automatic access(input string tag, input logic r, input logic s, input logic [11:0] a,
                        input logic [31:0] d, input logic inj);
    @(negedge clk);
    issue(r, s, a, d, inj);
    @(negedge clk);
    mem = 1'b0;
    wait_done(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; mem = 1'b0; rw = 1'b1; size = 1'b0; MAR = '0; MDR_in = '0; inj_par = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mdr", MDR_out, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_aerr", {31'd0, addr_err}, 32'd0);
    check("rst_perr", {31'd0, parity_err}, 32'd0);
    reset = 1'b1;

    access("t1_rd10", 1'b1, 1'b0, 12'd10, 32'h0, 1'b0);
    access("t2_wr10", 1'b0, 1'b0, 12'd10, 32'd100, 1'b0);
    access("t2_rd10", 1'b1, 1'b0, 12'd10, 32'h0, 1'b0);

    access("t3_wr200", 1'b0, 1'b1, 12'd200, 32'h12345678, 1'b0);
    access("t3_rd200", 1'b1, 1'b1, 12'd200, 32'h0, 1'b0);
    access("t3_rd201", 1'b1, 1'b0, 12'd201, 32'h0, 1'b0);

    access("t4_wrfff", 1'b0, 1'b1, 12'hFFF, 32'hDEADBEEF, 1'b0);
    access("t4_rdfff_d", 1'b1, 1'b1, 12'hFFF, 32'h0, 1'b0);
    access("t4_rdfff", 1'b1, 1'b0, 12'hFFF, 32'h0, 1'b0);
    access("t4_rd000", 1'b1, 1'b0, 12'h000, 32'h0, 1'b0);

    // Stray request during BEAT1 must not disturb the latched address.
    access("t5_wr30", 1'b0, 1'b1, 12'd30, 32'hA5A55A5A, 1'b0);
    access("t5_wr32", 1'b0, 1'b0, 12'd32, 32'h00000BAD, 1'b0);
    @(negedge clk);
    issue(1'b1, 1'b1, 12'd30, 32'h0, 1'b0);
    @(negedge clk);
    mem = 1'b0;
    @(negedge clk);
    check("t5_beat1_busy", {31'd0, busy}, 32'd1);
    mem = 1'b1; rw = 1'b1; size = 1'b0; MAR = 12'd31;
    @(negedge clk);
    mem = 1'b0;
    check_done_now("t5_rd30");
    @(negedge clk);
    check("t5_stray_ignored", {31'd0, busy}, 32'd0);

    // Back-to-back: second request accepted in the first one's done cycle.
    @(negedge clk);
    issue(1'b0, 1'b0, 12'd40, 32'h00001111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_done_now("t5_b2b_wr");
    issue(1'b1, 1'b0, 12'd40, 32'h0, 1'b0);
    @(negedge clk);
    mem = 1'b0;
    wait_done("t5_b2b_rd");

    // Reset in BEAT1 of a double write aborts it silently.
    @(negedge clk);
    mem = 1'b1; rw = 1'b0; size = 1'b1; MAR = 12'd50; MDR_in = 32'hCAFEBABE; inj_par = 1'b0;
    @(negedge clk);
    mem = 1'b0;
    @(negedge clk);
    check("t6_beat1_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_done", {31'd0, done}, 32'd0);
    check("t6_rst_mdr", MDR_out, 32'h0);
    reset = 1'b1;
    model_reset();
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("t6_no_done", 32'(ndone), 32'd0);
    access("t6_rd50", 1'b1, 1'b1, 12'd50, 32'h0, 1'b0);
    access("t6_rd10_cleared", 1'b1, 1'b0, 12'd10, 32'h0, 1'b0);

    access("t6_wr20_inj", 1'b0, 1'b0, 12'd20, 32'h00000005, 1'b1);
    access("t6_rd20", 1'b1, 1'b0, 12'd20, 32'h0, 1'b0);
    access("t6_wr21", 1'b0, 1'b0, 12'd21, 32'h00000007, 1'b0);
    access("t6_rd21", 1'b1, 1'b0, 12'd21, 32'h0, 1'b0);
    access("t6_rd20_d", 1'b1, 1'b1, 12'd20, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
